hazard_fwd_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).
- Decodes register-read usage of the decode-stage instruction and keeps its own shadow copy of the EX/MEM/WB destination info.
- From these it drives the forwarding-mux selects for EX, load-use stalls and bubbles, taken-branch flushes and a global memory-wait freeze.
- Sits beside the pipeline registers in the CPU top level; it contains no datapath.

---
 rtl/hazard_fwd_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage RV32I pipeline.
// Keeps a shadow of EX/MEM/WB destination info, selects EX operand
// forwarding, inserts load-use bubbles, flushes on taken branches and
// freezes the whole pipeline while data memory is busy.
module hazard_fwd_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_inst,
   input  logic             id_valid,
   input  logic             ex_taken,
   input  logic             mem_ready,
   output logic             stall_if,
   output logic             stall_id,
   output logic             stall_ex,
   output logic             stall_mem,
   output logic             flush_id,
   output logic             bubble_ex,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] load_use_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [4:0] OP_R     = 5'b01100;
   localparam logic [4:0] OP_ICAL  = 5'b00100;
   localparam logic [4:0] OP_LOAD  = 5'b00000;
   localparam logic [4:0] OP_S     = 5'b01000;
   localparam logic [4:0] OP_B     = 5'b11000;
   localparam logic [4:0] OP_JALR  = 5'b11001;
   localparam logic [4:0] OP_LUI   = 5'b01101;
   localparam logic [4:0] OP_AUIPC = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b11011;

   // Decoded ID-stage fields
   logic [4:0] dec_rs1_s, dec_rs2_s, dec_rd_s;
   logic       dec_re1_s, dec_re2_s, dec_we_s, dec_ld_s;

   // EX/MEM/WB shadow state
   logic [4:0] ex_rs1_q, ex_rs2_q, ex_rd_q, mem_rd_q, wb_rd_q;
   logic       ex_re1_q, ex_re2_q, ex_we_q, ex_ld_q;
   logic       mem_we_q, mem_ld_q, wb_we_q;

   logic [CNT_W-1:0] lu_cnt_q, fl_cnt_q;

   logic       lu_s, bubble_s;
   logic [1:0] fwd_a_s, fwd_b_s;
   logic       unused_s;

   // Funct fields and the low opcode bits carry no hazard information.
   assign unused_s = ^{id_inst[31:25], id_inst[14:12], id_inst[1:0], mem_ld_q};

   assign dec_rs1_s = id_inst[19:15];
   assign dec_rs2_s = id_inst[24:20];
   assign dec_rd_s  = id_inst[11:7];

   // Register-usage decode of the instruction in IF/ID; bubbles use nothing.
   always_comb begin
      dec_re1_s = 1'b0;
      dec_re2_s = 1'b0;
      dec_we_s  = 1'b0;
      dec_ld_s  = 1'b0;
      case (id_inst[6:2])
         OP_R:    begin dec_re1_s = 1'b1; dec_re2_s = 1'b1; dec_we_s = 1'b1; end
         OP_ICAL: begin dec_re1_s = 1'b1; dec_we_s = 1'b1; end
         OP_LOAD: begin dec_re1_s = 1'b1; dec_we_s = 1'b1; dec_ld_s = 1'b1; end
         OP_S:    begin dec_re1_s = 1'b1; dec_re2_s = 1'b1; end
         OP_B:    begin dec_re1_s = 1'b1; dec_re2_s = 1'b1; end
         OP_JALR: begin dec_re1_s = 1'b1; dec_we_s = 1'b1; end
         OP_LUI, OP_AUIPC, OP_JAL: begin dec_we_s = 1'b1; end
         default: begin dec_re1_s = 1'b0; end
      endcase
      if (dec_rd_s == 5'd0) begin
         dec_we_s = 1'b0;
      end else begin
         dec_we_s = dec_we_s;
      end
      if (!id_valid) begin
         dec_re1_s = 1'b0;
         dec_re2_s = 1'b0;
         dec_we_s  = 1'b0;
         dec_ld_s  = 1'b0;
      end else begin
         dec_ld_s  = dec_ld_s;
      end
   end

   // A load in EX whose destination is read by the ID instruction must wait a cycle.
   assign lu_s = ex_ld_q && ex_we_q &&
                 ((dec_re1_s && (dec_rs1_s == ex_rd_q)) ||
                  (dec_re2_s && (dec_rs2_s == ex_rd_q)));

   assign bubble_s = mem_ready && (ex_taken || lu_s);

   // EX operand select: the younger MEM result wins over WB.
   always_comb begin
      fwd_a_s = 2'b00;
      fwd_b_s = 2'b00;
      if (ex_re1_q && mem_we_q && (mem_rd_q == ex_rs1_q)) begin
         fwd_a_s = 2'b01;
      end else if (ex_re1_q && wb_we_q && (wb_rd_q == ex_rs1_q)) begin
         fwd_a_s = 2'b10;
      end else begin
         fwd_a_s = 2'b00;
      end
      if (ex_re2_q && mem_we_q && (mem_rd_q == ex_rs2_q)) begin
         fwd_b_s = 2'b01;
      end else if (ex_re2_q && wb_we_q && (wb_rd_q == ex_rs2_q)) begin
         fwd_b_s = 2'b10;
      end else begin
         fwd_b_s = 2'b00;
      end
   end

   // Pipeline control outputs, forced quiet while reset is held.
   always_comb begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      bubble_ex = 1'b0;
      fwd_a     = 2'b00;
      fwd_b     = 2'b00;
      if (rst) begin
         fwd_a = 2'b00;
      end else begin
         fwd_a = fwd_a_s;
         fwd_b = fwd_b_s;
         if (!mem_ready) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
         end else if (ex_taken) begin
            flush_id  = 1'b1;
            bubble_ex = 1'b1;
         end else if (lu_s) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            bubble_ex = 1'b1;
         end else begin
            bubble_ex = 1'b0;
         end
      end
   end

   // Advance the shadow pipeline unless memory is freezing everything.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_rs1_q <= 5'd0; ex_rs2_q <= 5'd0; ex_rd_q <= 5'd0;
         ex_re1_q <= 1'b0; ex_re2_q <= 1'b0; ex_we_q <= 1'b0; ex_ld_q <= 1'b0;
         mem_rd_q <= 5'd0; mem_we_q <= 1'b0; mem_ld_q <= 1'b0;
         wb_rd_q  <= 5'd0; wb_we_q  <= 1'b0;
      end else if (mem_ready) begin
         wb_rd_q  <= mem_rd_q;
         wb_we_q  <= mem_we_q;
         mem_rd_q <= ex_rd_q;
         mem_we_q <= ex_we_q;
         mem_ld_q <= ex_ld_q;
         if (bubble_s) begin
            ex_rs1_q <= 5'd0; ex_rs2_q <= 5'd0; ex_rd_q <= 5'd0;
            ex_re1_q <= 1'b0; ex_re2_q <= 1'b0; ex_we_q <= 1'b0; ex_ld_q <= 1'b0;
         end else begin
            ex_rs1_q <= dec_rs1_s; ex_rs2_q <= dec_rs2_s; ex_rd_q <= dec_rd_s;
            ex_re1_q <= dec_re1_s; ex_re2_q <= dec_re2_s;
            ex_we_q  <= dec_we_s;  ex_ld_q  <= dec_ld_s;
         end
      end else begin
         wb_we_q <= wb_we_q;
      end
   end

   // Saturating event counters; nothing counts during a memory freeze.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lu_cnt_q <= {CNT_W{1'b0}};
         fl_cnt_q <= {CNT_W{1'b0}};
      end else if (mem_ready && ex_taken) begin
         if (fl_cnt_q != {CNT_W{1'b1}}) begin
            fl_cnt_q <= fl_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            fl_cnt_q <= fl_cnt_q;
         end
      end else if (mem_ready && lu_s) begin
         if (lu_cnt_q != {CNT_W{1'b1}}) begin
            lu_cnt_q <= lu_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            lu_cnt_q <= lu_cnt_q;
         end
      end else begin
         lu_cnt_q <= lu_cnt_q;
      end
   end

   assign load_use_cnt = lu_cnt_q;
   assign flush_cnt    = fl_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: per-cycle expected control
// values are queued when stimulus is applied and compared mid-cycle.
module tb_hazard_fwd_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   id_inst;
   logic          id_valid, ex_taken, mem_ready;
   logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex;
   logic [1:0]    fwd_a, fwd_b;
   logic [CW-1:0] load_use_cnt, flush_cnt;

   hazard_fwd_ctrl #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
      .ex_taken(ex_taken), .mem_ready(mem_ready),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
      .stall_mem(stall_mem), .flush_id(flush_id), .bubble_ex(bubble_ex),
      .fwd_a(fwd_a), .fwd_b(fwd_b),
      .load_use_cnt(load_use_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    st;
      logic          fl;
      logic          bb;
      logic [1:0]    fa;
      logic [1:0]    fb;
      logic [CW-1:0] luc;
      logic [CW-1:0] flc;
   } exp_t;

   exp_t          sb[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   logic [CW-1:0] exp_lu   = '0;
   logic [CW-1:0] exp_fl   = '0;

   localparam logic [3:0] ST_NO  = 4'b0000;
   localparam logic [3:0] ST_LU  = 4'b1100;
   localparam logic [3:0] ST_ALL = 4'b1111;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h000, rs1, 3'b010, rd, 7'b0000011};
   endfunction

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction

   // Apply one cycle of stimulus and queue what the controller must show.
   task automatic step(input logic [31:0] inst, input logic v, input logic tk,
                       input logic rdy, input logic [3:0] st, input logic fl,
                       input logic bb, input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      @(posedge clk);
      #1;
      id_inst   = inst;
      id_valid  = v;
      ex_taken  = tk;
      mem_ready = rdy;
      e = '{st: st, fl: fl, bb: bb, fa: fa, fb: fb, luc: exp_lu, flc: exp_fl};
      sb.push_back(e);
      if (rdy && tk) begin
         if (exp_fl != {CW{1'b1}}) exp_fl = exp_fl + 1'b1;
      end else if (rdy && bb) begin
         if (exp_lu != {CW{1'b1}}) exp_lu = exp_lu + 1'b1;
      end
   endtask

   task automatic bub();
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) bub();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_stall"}, {28'h0, stall_if, stall_id, stall_ex, stall_mem}, 32'h0);
      chk({tag, "_flush"}, {31'h0, flush_id}, 32'h0);
      chk({tag, "_bubble"}, {31'h0, bubble_ex}, 32'h0);
      chk({tag, "_fwd"}, {28'h0, fwd_a, fwd_b}, 32'h0);
      chk({tag, "_cnt"}, {24'h0, load_use_cnt, flush_cnt}, 32'h0);
   endtask

   // Compare the DUT against the oldest queued expectation, mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("stalls", {28'h0, stall_if, stall_id, stall_ex, stall_mem}, {28'h0, e.st});
         chk("flush_id", {31'h0, flush_id}, {31'h0, e.fl});
         chk("bubble_ex", {31'h0, bubble_ex}, {31'h0, e.bb});
         chk("fwd_a", {30'h0, fwd_a}, {30'h0, e.fa});
         chk("fwd_b", {30'h0, fwd_b}, {30'h0, e.fb});
         chk("load_use_cnt", {28'h0, load_use_cnt}, {28'h0, e.luc});
         chk("flush_cnt", {28'h0, flush_cnt}, {28'h0, e.flc});
      end
   end

   initial begin
      // Reset held with inputs that would otherwise stall and flush.
      rst       = 1'b1;
      id_inst   = r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2);
      id_valid  = 1'b1;
      ex_taken  = 1'b1;
      mem_ready = 1'b0;
      #3;
      chk_zero("rst_hold");
      repeat (2) @(posedge clk);
      #2;
      chk_zero("rst_clk");
      rst      = 1'b0;
      id_valid = 1'b0;
      ex_taken = 1'b0;
      mem_ready = 1'b1;

      // lw x5,0(x1); add x6,x5,x2
      step(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_LU, 1'b0, 1'b1, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b10, 2'b00);
      drain();

      // add x3,x1,x2; sub x4,x3,x3; or x7,x3,x0
      step(r_op(7'h00, 3'b000, 5'd3, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h20, 3'b000, 5'd4, 5'd3, 5'd3), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b110, 5'd7, 5'd3, 5'd0), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b01, 2'b01);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b10, 2'b00);
      drain();

      // addi x0,x0,1; lw x0,0(x1); add x2,x0,x0: x0 never forwards or stalls
      step(addi(5'd0, 5'd0, 12'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(lw(5'd0, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd2, 5'd0, 5'd0), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      drain();

      // Taken branch overrides a load-use pair
      step(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd5), 1'b1, 1'b1, 1'b1, ST_NO, 1'b1, 1'b1, 2'b00, 2'b00);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      drain();

      // Memory freeze for 3 cycles over a load-use pair
      step(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      for (int i = 0; i < 3; i++)
         step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b0, ST_ALL, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_LU, 1'b0, 1'b1, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b10, 2'b00);
      drain();

      // Drive load_use_cnt into saturation and one pair beyond
      for (int k = 0; k < 14; k++) begin
         step(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
         step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_LU, 1'b0, 1'b1, 2'b00, 2'b00);
         step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
         step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b10, 2'b00);
         drain();
      end
      @(negedge clk);
      chk("lu_sat", {28'h0, load_use_cnt}, 32'hF);

      // Asynchronous reset in the middle of a load-use stall
      step(lw(5'd5, 5'd1), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_LU, 1'b0, 1'b1, 2'b00, 2'b00);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk_zero("rst_async");
      #1;
      rst    = 1'b0;
      exp_lu = '0;
      exp_fl = '0;
      step(r_op(7'h00, 3'b000, 5'd6, 5'd5, 5'd2), 1'b1, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      step(32'h0, 1'b0, 1'b0, 1'b1, ST_NO, 1'b0, 1'b0, 2'b00, 2'b00);
      @(negedge clk);
      #1;
      chk("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
